// File: rtl/joypad_ports.sv
// Purpose: NES $4016/$4017 controller ports with strobe/latch/serial shift, optional Four Score and per-button turbo.
// Latency: read data is combinational (zero cycles); shift, latch and strobe updates land at the end of the bus_ce cycle.
// Backpressure: none; every bus_ce access completes in its own cycle and no access is ever stalled.
module joypad_ports #(
    parameter int          NUM_PORTS    = 2,
    parameter int          TURBO_FRAMES = 2,
    parameter logic [7:0]  OPEN_BUS     = 8'h40,
    parameter logic [15:0] BASE_ADDR    = 16'h4016
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              bus_addr,
    input  logic                     bus_rw,
    input  logic                     bus_ce,
    input  logic [7:0]               bus_din,
    input  logic [8*NUM_PORTS-1:0]   buttons,
    input  logic [2*NUM_PORTS-1:0]   turbo_en,
    input  logic                     frame_tick,
    output logic [7:0]               data_out,
    output logic                     data_sel,
    output logic                     strobe
);

    // Reads past this many bits return 1, like an unplugged/exhausted pad.
    localparam logic [4:0]  LIMIT      = (NUM_PORTS == 4) ? 5'd24 : 5'd8;
    localparam logic [3:0]  LAST_FRAME = 4'(TURBO_FRAMES - 1);
    localparam logic [15:0] ADDR_B     = BASE_ADDR + 16'd1;

    // Four Score signature bytes, LSB shifted out first.
    localparam logic [7:0]  SIG_A      = 8'h08;
    localparam logic [7:0]  SIG_B      = 8'h04;

    if (NUM_PORTS != 2 && NUM_PORTS != 4) begin : g_bad_ports
        $error("joypad_ports: NUM_PORTS must be 2 or 4");
    end

    if (TURBO_FRAMES < 1 || TURBO_FRAMES > 15) begin : g_bad_turbo
        $error("joypad_ports: TURBO_FRAMES must be in 1..15");
    end

    // Address decode and access qualification
    logic sel_a;
    logic sel_b;
    logic rd_a;
    logic rd_b;
    logic wr_strobe;
    logic latch;

    assign sel_a     = (bus_addr == BASE_ADDR);
    assign sel_b     = (bus_addr == ADDR_B);
    assign data_sel  = bus_rw & (sel_a | sel_b);
    assign rd_a      = bus_ce & bus_rw & sel_a;
    assign rd_b      = bus_ce & bus_rw & sel_b;
    // Only the base address owns the strobe; base+1 writes go to the APU frame counter.
    assign wr_strobe = bus_ce & ~bus_rw & sel_a;
    // Reload while strobe is high, and also on the very write that drops it,
    // so the buttons seen in that cycle are the ones captured.
    assign latch     = strobe | (wr_strobe & ~bus_din[0]);

    // Turbo state
    logic       phase;
    logic [3:0] frame_cnt;

    // Effective buttons: turbo masks A/B while phase is low.
    logic [NUM_PORTS-1:0][7:0] eff;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_eff
        assign eff[p] = buttons[8*p +: 8]
                      & ~{6'b0, turbo_en[2*p+1] & ~phase, turbo_en[2*p] & ~phase};
    end

    // Parallel-load images for both streams
    logic [23:0] reload_a;
    logic [23:0] reload_b;

    if (NUM_PORTS == 4) begin : g_four
        assign reload_a = {SIG_A, eff[2], eff[0]};
        assign reload_b = {SIG_B, eff[3], eff[1]};
    end else begin : g_two
        assign reload_a = {16'h0000, eff[0]};
        assign reload_b = {16'h0000, eff[1]};
    end

    // Stream state
    logic [23:0] sr_a;
    logic [23:0] sr_b;
    logic [4:0]  cnt_a;
    logic [4:0]  cnt_b;

    // Read bit per stream: live A while strobed, else head until exhausted, then 1.
    logic bit_a;
    logic bit_b;

    // Select the serial bit presented on each stream's read port
    always_comb begin
        bit_a = 1'b1;
        bit_b = 1'b1;
        if (strobe) begin
            bit_a = eff[0][0];
            bit_b = eff[1][0];
        end else begin
            if (cnt_a < LIMIT) begin
                bit_a = sr_a[0];
            end
            if (cnt_b < LIMIT) begin
                bit_b = sr_b[0];
            end
        end
    end

    assign data_out = {OPEN_BUS[7:1], sel_b ? bit_b : bit_a};

    // Strobe register written by the CPU at the base address
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe <= 1'b0;
        end else if (wr_strobe) begin
            strobe <= bus_din[0];
        end
    end

    // Turbo frame counter and phase; free-running regardless of strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 4'd0;
            phase     <= 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= 4'd0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 4'd1;
            end
        end
    end

    // Stream A shift register and saturating read counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_a  <= 24'd0;
            cnt_a <= 5'd0;
        end else if (latch) begin
            sr_a  <= reload_a;
            cnt_a <= 5'd0;
        end else if (rd_a) begin
            sr_a <= {1'b0, sr_a[23:1]};
            if (cnt_a != LIMIT) begin
                cnt_a <= cnt_a + 5'd1;
            end
        end
    end

    // Stream B shift register and saturating read counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_b  <= 24'd0;
            cnt_b <= 5'd0;
        end else if (latch) begin
            sr_b  <= reload_b;
            cnt_b <= 5'd0;
        end else if (rd_b) begin
            sr_b <= {1'b0, sr_b[23:1]};
            if (cnt_b != LIMIT) begin
                cnt_b <= cnt_b + 5'd1;
            end
        end
    end

    // Only bit 0 of the write data is meaningful.
    logic unused_din;
    assign unused_din = ^bus_din[7:1];

endmodule

// File: tb/tb_joypad_ports.sv
module tb_joypad_ports;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic        bus_ce;
    logic [7:0]  bus_din;
    logic        frame_tick;

    logic [15:0] buttons2;
    logic [3:0]  turbo2;
    logic [7:0]  dout2;
    logic        sel2;
    logic        stb2;

    logic [31:0] buttons4;
    logic [7:0]  turbo4;
    logic [7:0]  dout4;
    logic        sel4;
    logic        stb4;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    joypad_ports #(.NUM_PORTS(2), .TURBO_FRAMES(2)) dut2 (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_ce(bus_ce),
        .bus_din(bus_din), .buttons(buttons2), .turbo_en(turbo2), .frame_tick(frame_tick),
        .data_out(dout2), .data_sel(sel2), .strobe(stb2)
    );

    joypad_ports #(.NUM_PORTS(4), .TURBO_FRAMES(2)) dut4 (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_ce(bus_ce),
        .bus_din(bus_din), .buttons(buttons4), .turbo_en(turbo4), .frame_tick(frame_tick),
        .data_out(dout4), .data_sel(sel4), .strobe(stb4)
    );

    function automatic logic [7:0] rdv(input logic b);
        return {7'h20, b};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_rw = 1'b0; bus_din = d; bus_ce = 1'b1;
        @(posedge clk);
        #1;
        bus_ce = 1'b0; bus_rw = 1'b1; bus_din = 8'h00;
    endtask

    // Read (ce=1) or peek (ce=0); compares data_out with the scoreboard head.
    task automatic cpu_read(input logic [15:0] a, input bit four, input bit ce, input string tag);
        logic [7:0] obs;
        @(negedge clk);
        bus_addr = a; bus_rw = 1'b1; bus_ce = ce;
        #2;
        obs = four ? dout4 : dout2;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        bus_ce = 1'b0;
    endtask

    task automatic peek_sel(input logic [15:0] a, input logic exp, input string tag);
        @(negedge clk);
        bus_addr = a; bus_rw = 1'b1; bus_ce = 1'b0;
        #2;
        check(tag, {7'b0, sel2}, {7'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] p3;
        logic [7:0] sig_b;
        logic       ph;
        int         ticks;

        reset = 1'b1; bus_addr = 16'h4016; bus_rw = 1'b1; bus_ce = 1'b0; bus_din = 8'h00;
        frame_tick = 1'b0; buttons2 = '0; turbo2 = '0; buttons4 = '0; turbo4 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_strobe2", {7'b0, stb2}, 8'h00);
        check("rst_strobe4", {7'b0, stb4}, 8'h00);
        exp_q.push_back(8'h40);
        cpu_read(16'h4016, 1'b0, 1'b0, "rst_dout2");
        exp_q.push_back(8'h40);
        cpu_read(16'h4017, 1'b1, 1'b0, "rst_dout4");
        peek_sel(16'h4016, 1'b1, "rst_sel");

        // 2-port shift: eight pad bits then ones
        pat = 8'b1000_0101;
        buttons2 = {8'h00, pat};
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(rdv(i < 8 ? pat[i] : 1'b1));
            cpu_read(16'h4016, 1'b0, 1'b1, "shift2");
        end

        // Strobe held: live A bit, nothing advances
        cpu_write(16'h4016, 8'h01);
        check("strobe_set", {7'b0, stb2}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            buttons2[0] = i[0];
            exp_q.push_back(rdv(i[0]));
            cpu_read(16'h4016, 1'b0, 1'b1, "strobe_live");
        end
        pat = 8'b0000_0010;
        buttons2 = {8'h00, pat};
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rdv(pat[i]));
            cpu_read(16'h4016, 1'b0, 1'b1, "strobe_cnt0");
        end

        // Four Score on stream B, then stream A intact
        p0 = 8'h01; p1 = 8'hFF; p2 = 8'hAA; p3 = 8'h00; sig_b = 8'h04;
        buttons4 = {p3, p2, p1, p0};
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 26; i++) begin
            if (i < 8)       exp_q.push_back(rdv(p1[i]));
            else if (i < 16) exp_q.push_back(rdv(p3[i-8]));
            else if (i < 24) exp_q.push_back(rdv(sig_b[i-16]));
            else             exp_q.push_back(rdv(1'b1));
            cpu_read(16'h4017, 1'b1, 1'b1, "four_b");
        end
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(rdv(i < 8 ? p0[i] : p2[i-8]));
            cpu_read(16'h4016, 1'b1, 1'b1, "four_a");
        end

        // Turbo on A, one latch+read per frame
        buttons2 = 16'h0001;
        turbo2 = 4'b0001;
        ticks = 0;
        for (int f = 0; f < 8; f++) begin
            if (f > 0) begin
                pulse_tick();
                ticks++;
            end
            cpu_write(16'h4016, 8'h01);
            cpu_write(16'h4016, 8'h00);
            ph = ((ticks / 2) % 2) == 0;
            exp_q.push_back(rdv(ph));
            cpu_read(16'h4016, 1'b0, 1'b1, "turbo");
        end

        // Side effects: no-ce read, write to base+1, out-of-range address
        turbo2 = 4'b0000;
        pat = 8'h05;
        buttons2 = {8'h00, pat};
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        exp_q.push_back(rdv(pat[0]));
        cpu_read(16'h4016, 1'b0, 1'b0, "noce_peek");
        exp_q.push_back(rdv(pat[0]));
        cpu_read(16'h4016, 1'b0, 1'b1, "noce_read0");
        exp_q.push_back(rdv(pat[1]));
        cpu_read(16'h4016, 1'b0, 1'b1, "noce_read1");
        cpu_write(16'h4017, 8'h01);
        check("wr4017_strobe", {7'b0, stb2}, 8'h00);
        exp_q.push_back(rdv(pat[2]));
        cpu_read(16'h4016, 1'b0, 1'b1, "wr4017_read2");
        peek_sel(16'h4018, 1'b0, "sel_4018");
        peek_sel(16'h4017, 1'b1, "sel_4017");

        // Reset mid-read wins over a same-cycle strobe write
        buttons2 = 16'hFFFF;
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rdv(1'b1));
            cpu_read(16'h4016, 1'b0, 1'b1, "prereset");
        end
        @(negedge clk);
        reset = 1'b1; bus_addr = 16'h4016; bus_rw = 1'b0; bus_din = 8'h01; bus_ce = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; bus_ce = 1'b0; bus_rw = 1'b1; bus_din = 8'h00;
        check("rst_mid_strobe2", {7'b0, stb2}, 8'h00);
        check("rst_mid_strobe4", {7'b0, stb4}, 8'h00);
        exp_q.push_back(rdv(1'b0));
        cpu_read(16'h4016, 1'b0, 1'b1, "postreset_a0");
        exp_q.push_back(rdv(1'b0));
        cpu_read(16'h4016, 1'b0, 1'b1, "postreset_a1");
        exp_q.push_back(rdv(1'b0));
        cpu_read(16'h4017, 1'b0, 1'b1, "postreset_b");
        exp_q.push_back(rdv(1'b0));
        cpu_read(16'h4016, 1'b1, 1'b1, "postreset_four");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
